pc_run_ctrl: RTL and testbench

- Sequencer for the program counter register in the single-cycle CPU.
- Selects the next PC each cycle from sequential, branch and jump sources.
- Gates instruction commit through a run/step/breakpoint debug FSM.
- When execution is not allowed, feeds the PC register its current value, so the PC holds without needing an enable.

---
 rtl/cpu_ctrl_pkg.sv | 12 +
 rtl/next_pc_mux.sv | 30 +++
 rtl/pc_run_ctrl.sv | 96 +++++++++
 tb/tb_pc_run_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and state encoding for the CPU run-control logic.
package cpu_ctrl_pkg;
    localparam int PC_W           = 32;
    localparam int INST_BYTES_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_BREAK = 2'd3
    } run_state_t;
endpackage

// File: rtl/next_pc_mux.sv
// Next-PC selection: hold when not committing, else jump > branch > sequential.
module next_pc_mux
    import cpu_ctrl_pkg::*;
#(
    parameter int INST_BYTES = INST_BYTES_DEF
) (
    input  logic [PC_W-1:0] cur_pc,
    input  logic            commit,
    input  logic            halt_instr,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] next_pc
);
    logic [PC_W-1:0] seq_pc;

    assign seq_pc = cur_pc + PC_W'(INST_BYTES);

    always_comb begin
        next_pc = cur_pc;
        if (commit) begin
            // A halt always falls through so the PC parks just past it.
            if (halt_instr)        next_pc = seq_pc;
            else if (jump)         next_pc = {jump_target[PC_W-1:2], 2'b00};
            else if (branch_taken) next_pc = {branch_target[PC_W-1:2], 2'b00};
            else                   next_pc = seq_pc;
        end
    end
endmodule

// File: rtl/pc_run_ctrl.sv
// Run/step/breakpoint sequencer for the PC register; gates instruction commit.
module pc_run_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int INST_BYTES = INST_BYTES_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PC_W-1:0]  cur_pc,
    input  logic             run,
    input  logic             step,
    input  logic             resume,
    input  logic             brk_en,
    input  logic [PC_W-1:0]  brk_addr,
    input  logic             jump,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    input  logic             halt_instr,
    output logic [PC_W-1:0]  next_pc,
    output logic             commit,
    output logic [1:0]       state,
    output logic             brk_hit,
    output logic             step_done,
    output logic [CNT_W-1:0] inst_count
);
    run_state_t cur_st, nxt_st;
    logic       skip, set_skip, hit_nxt, brk_match;

    // skip masks the breakpoint until the trapped instruction has executed once.
    assign brk_match = brk_en && (cur_pc == brk_addr) && !skip;
    assign commit    = (cur_st == ST_STEP) || (cur_st == ST_RUN && !brk_match);
    assign state     = cur_st;

    always_comb begin
        nxt_st   = cur_st;
        set_skip = 1'b0;
        hit_nxt  = 1'b0;
        case (cur_st)
            ST_IDLE: begin
                if (run)       nxt_st = ST_RUN;
                else if (step) nxt_st = ST_STEP;
            end
            ST_RUN: begin
                if (halt_instr)     nxt_st = ST_IDLE;
                else if (brk_match) begin
                    nxt_st  = ST_BREAK;
                    hit_nxt = 1'b1;
                end
                else if (!run)      nxt_st = ST_IDLE;
            end
            ST_STEP: nxt_st = ST_IDLE;
            ST_BREAK: begin
                if (!run) nxt_st = ST_IDLE;
                else if (resume) begin
                    nxt_st   = ST_RUN;
                    set_skip = 1'b1;
                end
                else if (step) begin
                    nxt_st   = ST_STEP;
                    set_skip = 1'b1;
                end
            end
            default: nxt_st = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_st     <= ST_IDLE;
            brk_hit    <= 1'b0;
            step_done  <= 1'b0;
            skip       <= 1'b0;
            inst_count <= '0;
        end else begin
            cur_st     <= nxt_st;
            brk_hit    <= hit_nxt;
            step_done  <= (cur_st == ST_STEP);
            inst_count <= inst_count + CNT_W'(commit);
            if (set_skip)    skip <= 1'b1;
            else if (commit) skip <= 1'b0;
        end
    end

    next_pc_mux #(.INST_BYTES(INST_BYTES)) u_mux (
        .cur_pc        (cur_pc),
        .commit        (commit),
        .halt_instr    (halt_instr),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc)
    );
endmodule

// File: tb/tb_pc_run_ctrl.sv
// Scoreboard bench for pc_run_ctrl with an external PC register model.
module tb_pc_run_ctrl;
    import cpu_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0]  st;
        logic        cmt;
        logic        bh;
        logic        sd;
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] cnt;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst, run, step, resume, brk_en, jump, branch_taken, halt_instr;
    logic [31:0] brk_addr, jump_target, branch_target, pc_q;
    logic [31:0] next_pc, inst_count;
    logic        commit, brk_hit, step_done;
    logic [1:0]  state;

    obs_t  exp_q[$];
    obs_t  obs_q[$];
    string tag_q[$];
    int    vecs  = 0;
    int    fails = 0;

    always #5 clk = ~clk;

    // PC register external to the controller; resets to 0 on its own.
    always_ff @(posedge clk) begin
        if (rst) pc_q <= 32'h0;
        else     pc_q <= next_pc;
    end

    pc_run_ctrl #(.CNT_W(32), .INST_BYTES(4)) dut (
        .clk(clk), .rst(rst), .cur_pc(pc_q), .run(run), .step(step), .resume(resume),
        .brk_en(brk_en), .brk_addr(brk_addr), .jump(jump), .jump_target(jump_target),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt_instr(halt_instr),
        .next_pc(next_pc), .commit(commit), .state(state), .brk_hit(brk_hit),
        .step_done(step_done), .inst_count(inst_count)
    );

    function automatic obs_t mk(input int st, input bit c, input bit bh, input bit sd,
                                input logic [31:0] pc, input logic [31:0] npc,
                                input logic [31:0] cnt);
        obs_t o;
        o.st = 2'(st); o.cmt = c; o.bh = bh; o.sd = sd; o.pc = pc; o.npc = npc; o.cnt = cnt;
        return o;
    endfunction

    // Push the expectation, capture the DUT mid-cycle, then advance past the next edge.
    task automatic drv(input obs_t e, input string tag);
        obs_t o;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        o.st = state; o.cmt = commit; o.bh = brk_hit; o.sd = step_done;
        o.pc = pc_q; o.npc = next_pc; o.cnt = inst_count;
        obs_q.push_back(o);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 0; step = 0; resume = 0; brk_en = 0; jump = 0;
        branch_taken = 0; halt_instr = 0; brk_addr = 0; jump_target = 0; branch_target = 0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o; string t;
        rst = 1'b1;
        drv(mk(0,0,0,0,0,0,0), "reset held");
        rst = 1'b0;
        drv(mk(0,0,0,0,0,0,0), "reset released");
        drv(mk(0,0,0,0,0,0,0), "idle no run");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); vecs++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s: got st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d, exp st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d",
                         t, o.st, o.cmt, o.bh, o.sd, o.pc, o.npc, o.cnt, e.st, e.cmt, e.bh, e.sd, e.pc, e.npc, e.cnt);
            end
        end
    endtask

    task automatic test_run();
        obs_t e, o; string t;
        do_reset();
        run = 1;
        drv(mk(0,0,0,0,32'h0,32'h0,0),  "run idle");
        drv(mk(1,1,0,0,32'h0,32'h4,0),  "run pc0");
        drv(mk(1,1,0,0,32'h4,32'h8,1),  "run pc4");
        drv(mk(1,1,0,0,32'h8,32'hC,2),  "run pc8");
        run = 0;
        drv(mk(1,1,0,0,32'hC,32'h10,3), "run stop commits");
        drv(mk(0,0,0,0,32'h10,32'h10,4), "run stopped hold");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); vecs++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s: got st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d, exp st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d",
                         t, o.st, o.cmt, o.bh, o.sd, o.pc, o.npc, o.cnt, e.st, e.cmt, e.bh, e.sd, e.pc, e.npc, e.cnt);
            end
        end
    endtask

    task automatic test_step();
        obs_t e, o; string t;
        do_reset();
        step = 1;
        drv(mk(0,0,0,0,32'h0,32'h0,0), "step request");
        step = 0;
        drv(mk(2,1,0,0,32'h0,32'h4,0), "step commit");
        drv(mk(0,0,0,1,32'h4,32'h4,1), "step done");
        for (int i = 0; i < 10; i++) drv(mk(0,0,0,0,32'h4,32'h4,1), "step hold");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); vecs++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s: got st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d, exp st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d",
                         t, o.st, o.cmt, o.bh, o.sd, o.pc, o.npc, o.cnt, e.st, e.cmt, e.bh, e.sd, e.pc, e.npc, e.cnt);
            end
        end
    endtask

    task automatic test_break();
        obs_t e, o; string t;
        do_reset();
        brk_en = 1; brk_addr = 32'h10; run = 1;
        drv(mk(0,0,0,0,32'h0,32'h0,0),   "brk idle");
        drv(mk(1,1,0,0,32'h0,32'h4,0),   "brk pc0");
        drv(mk(1,1,0,0,32'h4,32'h8,1),   "brk pc4");
        drv(mk(1,1,0,0,32'h8,32'hC,2),   "brk pc8");
        drv(mk(1,1,0,0,32'hC,32'h10,3),  "brk pcC");
        drv(mk(1,0,0,0,32'h10,32'h10,4), "brk match");
        drv(mk(3,0,1,0,32'h10,32'h10,4), "brk hit pulse");
        resume = 1;
        drv(mk(3,0,0,0,32'h10,32'h10,4), "brk pulse ends");
        resume = 0;
        drv(mk(1,1,0,0,32'h10,32'h14,4), "brk resume skip");
        jump = 1; jump_target = 32'h10;
        drv(mk(1,1,0,0,32'h14,32'h10,5), "brk loop back");
        jump = 0;
        drv(mk(1,0,0,0,32'h10,32'h10,6), "brk retrap");
        run = 0;
        drv(mk(3,0,1,0,32'h10,32'h10,6), "brk hit again");
        drv(mk(0,0,0,0,32'h10,32'h10,6), "brk run off idle");
        brk_en = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); vecs++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s: got st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d, exp st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d",
                         t, o.st, o.cmt, o.bh, o.sd, o.pc, o.npc, o.cnt, e.st, e.cmt, e.bh, e.sd, e.pc, e.npc, e.cnt);
            end
        end
    endtask

    task automatic test_priority();
        obs_t e, o; string t;
        do_reset();
        run = 1;
        drv(mk(0,0,0,0,32'h0,32'h0,0), "prio idle");
        jump = 1; jump_target = 32'h20;
        drv(mk(1,1,0,0,32'h0,32'h20,0), "prio jump to 20");
        jump_target = 32'h103; branch_taken = 1; branch_target = 32'h40;
        drv(mk(1,1,0,0,32'h20,32'h100,1), "prio jump over branch");
        jump = 0; branch_target = 32'h43;
        drv(mk(1,1,0,0,32'h100,32'h40,2), "prio branch aligned");
        branch_taken = 0; run = 0;
        drv(mk(1,1,0,0,32'h40,32'h44,3), "prio sequential");
        jump = 1; jump_target = 32'h80;
        drv(mk(0,0,0,0,32'h44,32'h44,4), "prio jump ignored idle");
        jump = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); vecs++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s: got st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d, exp st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d",
                         t, o.st, o.cmt, o.bh, o.sd, o.pc, o.npc, o.cnt, e.st, e.cmt, e.bh, e.sd, e.pc, e.npc, e.cnt);
            end
        end
    endtask

    task automatic test_halt_wrap();
        obs_t e, o; string t;
        do_reset();
        run = 1;
        drv(mk(0,0,0,0,32'h0,32'h0,0), "halt idle");
        drv(mk(1,1,0,0,32'h0,32'h4,0), "halt pc0");
        drv(mk(1,1,0,0,32'h4,32'h8,1), "halt pc4");
        halt_instr = 1; jump = 1; jump_target = 32'h200;
        drv(mk(1,1,0,0,32'h8,32'hC,2), "halt commits seq");
        halt_instr = 0; jump = 0;
        drv(mk(0,0,0,0,32'hC,32'hC,3), "halt to idle");
        jump = 1; jump_target = 32'hFFFF_FFFF;
        drv(mk(1,1,0,0,32'hC,32'hFFFF_FFFC,3), "wrap jump top");
        jump = 0; run = 0;
        drv(mk(1,1,0,0,32'hFFFF_FFFC,32'h0,4), "wrap to zero");
        drv(mk(0,0,0,0,32'h0,32'h0,5), "wrap idle");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); vecs++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s: got st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d, exp st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d",
                         t, o.st, o.cmt, o.bh, o.sd, o.pc, o.npc, o.cnt, e.st, e.cmt, e.bh, e.sd, e.pc, e.npc, e.cnt);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t e, o; string t;
        do_reset();
        brk_en = 1; brk_addr = 32'h4; run = 1;
        drv(mk(0,0,0,0,32'h0,32'h0,0), "b2b idle");
        step = 1;
        drv(mk(1,1,0,0,32'h0,32'h4,0), "b2b step ignored in run");
        step = 0;
        drv(mk(1,0,0,0,32'h4,32'h4,1), "b2b match");
        step = 1;
        drv(mk(3,0,1,0,32'h4,32'h4,1), "b2b break");
        step = 0;
        drv(mk(2,1,0,0,32'h4,32'h8,1), "b2b step from break");
        drv(mk(0,0,0,1,32'h8,32'h8,2), "b2b step done");
        run = 0;
        drv(mk(1,1,0,0,32'h8,32'hC,2), "b2b rerun");
        drv(mk(0,0,0,0,32'hC,32'hC,3), "b2b stopped");
        brk_en = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); vecs++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s: got st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d, exp st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d",
                         t, o.st, o.cmt, o.bh, o.sd, o.pc, o.npc, o.cnt, e.st, e.cmt, e.bh, e.sd, e.pc, e.npc, e.cnt);
            end
        end
    endtask

    task automatic test_mid_reset();
        obs_t e, o; string t;
        do_reset();
        run = 1;
        drv(mk(0,0,0,0,32'h0,32'h0,0), "mrst idle");
        drv(mk(1,1,0,0,32'h0,32'h4,0), "mrst pc0");
        drv(mk(1,1,0,0,32'h4,32'h8,1), "mrst pc4");
        drv(mk(1,1,0,0,32'h8,32'hC,2), "mrst pc8");
        drv(mk(1,1,0,0,32'hC,32'h10,3), "mrst pcC");
        drv(mk(1,1,0,0,32'h10,32'h14,4), "mrst pc10");
        rst = 1;
        drv(mk(1,1,0,0,32'h14,32'h18,5), "mrst asserted");
        rst = 0;
        drv(mk(0,0,0,0,32'h0,32'h0,0), "mrst cleared");
        run = 0;
        drv(mk(1,1,0,0,32'h0,32'h4,0), "mrst rerun");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); t = tag_q.pop_front(); vecs++;
            if (o !== e) begin
                fails++;
                $display("FAIL %s: got st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d, exp st=%0d cmt=%b bh=%b sd=%b pc=%h npc=%h cnt=%0d",
                         t, o.st, o.cmt, o.bh, o.sd, o.pc, o.npc, o.cnt, e.st, e.cmt, e.bh, e.sd, e.pc, e.npc, e.cnt);
            end
        end
    endtask

    initial begin
        rst = 1; run = 0; step = 0; resume = 0; brk_en = 0; jump = 0;
        branch_taken = 0; halt_instr = 0; brk_addr = 0; jump_target = 0; branch_target = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_run();
        test_step();
        test_break();
        test_priority();
        test_halt_wrap();
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end
endmodule
